// File: rtl/p2s_miso_tx.sv
// p2s_miso_tx: parallel-to-serial MISO transmitter for the SPI slave read path.
// Loads one word on tx_valid while idle, drives it MSB-first onto MISO one bit
// per enabled cycle, and pulses tx_done once the final bit has been consumed.
module p2s_miso_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  input  logic                  En_P2S,
  input  logic                  abort,
  output logic                  MISO,
  output logic                  tx_ready,
  output logic                  tx_busy,
  output logic                  tx_done
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] sreg, sreg_n;
  logic [CNT_W-1:0]      bit_cnt, cnt_n;
  logic                  miso_n, done_n;
  logic [CNT_W-1:0]      cnt_m1;
  logic [DATA_WIDTH-1:0] sreg_shr;

  // Next bit to present is sreg[bit_cnt-1]; a shift avoids an index-width mismatch
  // when CNT_W is wider than the bit position needs.
  assign cnt_m1   = bit_cnt - 1'b1;
  assign sreg_shr = sreg >> cnt_m1;

  // Status flags decode straight from the state register.
  assign tx_ready = (state == IDLE);
  assign tx_busy  = (state == SHIFT);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state and datapath next values; abort outranks everything in SHIFT.
  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    cnt_n   = bit_cnt;
    miso_n  = MISO;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        miso_n = 1'b0;
        if (tx_valid && !abort) begin
          sreg_n  = tx_data;
          cnt_n   = CNT_W'(DATA_WIDTH - 1);
          miso_n  = tx_data[DATA_WIDTH-1];
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_n = IDLE;
          miso_n  = 1'b0;
          cnt_n   = '0;
        end else if (En_P2S) begin
          if (bit_cnt != '0) begin
            miso_n = sreg_shr[0];
            cnt_n  = cnt_m1;
          end else begin
            miso_n  = 1'b0;
            done_n  = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
        miso_n  = 1'b0;
      end
    endcase
  end

  // Datapath registers: shift word, bit counter, registered MISO and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg    <= '0;
      bit_cnt <= '0;
      MISO    <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      sreg    <= sreg_n;
      bit_cnt <= cnt_n;
      MISO    <= miso_n;
      tx_done <= done_n;
    end
  end

endmodule
